// File: rtl/out_n_clock_pkg.sv
// Shared definitions for the out_n_clock strobe generator.
package out_n_clock_pkg;

    localparam int OUT_N_CLOCK_DEFAULT_N = 4;

    // Counter width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Free-running modulo-N counter with a look-ahead flag for the last count.
module mod_n_counter
    import out_n_clock_pkg::*;
#(
    parameter int N = OUT_N_CLOCK_DEFAULT_N,
    parameter int W = cnt_width(N)
) (
    input  logic         clock,
    input  logic         reset_,
    output logic [W-1:0] cnt,
    output logic         wrap_next
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_next;

    // Next count: wrap to zero after N-1.
    always_comb begin
        cnt_next = cnt + W'(1);
        if (cnt == LAST) begin
            cnt_next = '0;
        end
    end

    // Flags the edge that loads N-1, so the owner can register its strobe.
    assign wrap_next = (cnt_next == LAST);

    // Count state.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/out_n_clock.sv
// Periodic strobe generator: one-cycle pulse every N clocks.
// Build option OUT_N_CLOCK_SQUARE_EN turns the strobe into a square wave
// of period 2N by toggling instead of pulsing.
module out_n_clock
    import out_n_clock_pkg::*;
#(
    parameter int N = OUT_N_CLOCK_DEFAULT_N,
    parameter int W = cnt_width(N)
) (
    input  logic clock,
    input  logic reset_,
    output logic out
);

    if (N < 1) begin : g_bad_n
        $error("out_n_clock: N must be >= 1");
    end

    logic [W-1:0] unused_cnt;
    logic         wrap_next;

    mod_n_counter #(
        .N (N),
        .W (W)
    ) u_cnt (
        .clock     (clock),
        .reset_    (reset_),
        .cnt       (unused_cnt),
        .wrap_next (wrap_next)
    );

    // Output flop, loaded from the counter look-ahead so out tracks cnt==N-1.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            out <= 1'b0;
        end else begin
`ifdef OUT_N_CLOCK_SQUARE_EN
            out <= out ^ wrap_next;
`else
            out <= wrap_next;
`endif
        end
    end

endmodule

// File: tb/tb_out_n_clock.sv
// Directed scoreboard bench for out_n_clock with N = 4, 1, 2, 5 side by side.
module tb_out_n_clock;

    logic clock;
    logic reset_;
    logic out4, out1, out2, out5;

    typedef struct {
        int       inst;   // 0:N4 1:N1 2:N2 3:N5 4:N5 counter
        int       k;
        logic [3:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks;
    int  n_fail;
    int  k;

    out_n_clock #(.N(4)) u_n4 (.clock(clock), .reset_(reset_), .out(out4));
    out_n_clock #(.N(1)) u_n1 (.clock(clock), .reset_(reset_), .out(out1));
    out_n_clock #(.N(2)) u_n2 (.clock(clock), .reset_(reset_), .out(out2));
    out_n_clock #(.N(5)) u_n5 (.clock(clock), .reset_(reset_), .out(out5));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int inst_n(int inst);
        case (inst)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 5;
        endcase
    endfunction

    // Reference: output after k edges since release (k=0 means in/just after reset).
    function automatic logic exp_out(int n, int kk);
        int toggles;
        if (kk == 0) return 1'b0;
`ifdef OUT_N_CLOCK_SQUARE_EN
        toggles = (kk + 1) / n - ((n == 1) ? 1 : 0);
        return (toggles % 2) == 1;
`else
        toggles = 0;
        return ((kk + 1) % n) == 0;
`endif
    endfunction

    function automatic logic [3:0] observed(int inst);
        case (inst)
            0: return {3'b000, out4};
            1: return {3'b000, out1};
            2: return {3'b000, out2};
            3: return {3'b000, out5};
            default: return 4'(u_n5.u_cnt.cnt);
        endcase
    endfunction

    task automatic push_all(input int kk);
        sb_t e;
        for (int i = 0; i < 4; i++) begin
            e.inst = i;
            e.k    = kk;
            e.exp  = {3'b000, exp_out(inst_n(i), kk)};
            sb.push_back(e);
        end
        e.inst = 4;
        e.k    = kk;
        e.exp  = 4'(kk % 5);
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t        e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observed(e.inst);
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s_n%0d k=%0d observed=%0h expected=%0h",
                       (e.inst == 4) ? "cnt" : "out", inst_n(e.inst), e.k, obs, e.exp);
            end
        end
    endtask

    // One rising edge, then sample 2 time units later.
    task automatic step_edge();
        @(posedge clock);
        k++;
        push_all(k);
        #2;
        drain();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_ = 1'b1;
        k = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        reset_   = 1'b0;

        // Reset held for two cycles: everything low, counter at zero.
        repeat (2) begin
            @(negedge clock);
            push_all(0);
            drain();
        end

        // Free run for 30 edges.
        release_reset();
        repeat (30) step_edge();

        // Reset between edges must clear out immediately.
        @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        push_all(0);
        drain();
        release_reset();

        // Mid-period reset just after edge 5, held about one cycle.
        repeat (5) step_edge();
        reset_ = 1'b0;
        #1;
        push_all(0);
        drain();
        @(posedge clock);
        #2;
        push_all(0);
        drain();
        release_reset();
        repeat (12) step_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
